// File: rtl/spi_controller_pkg.sv
// Shared types and constants for the SPI mode-0 controller and its half-period timer.
package spi_controller_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, RELEASE} spi_ctrl_state_t;

    localparam logic SPI_CS_ENABLED = 1'b0;
    localparam logic SPI_SCK_IDLE   = 1'b0;

    // Wide enough for any legal CLK_DIV or CS_IDLE reload value (1..255).
    localparam int unsigned TIMER_W = $clog2(255 + 1);

endpackage

// File: rtl/spi_half_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module spi_half_timer
    import spi_controller_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    output logic               tc
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator, MSB first: one byte per start_i, optional CS hold across bytes.
module spi_controller
    import spi_controller_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_IDLE = 4
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [7:0] tx_byte_i,
    input  logic       cs_hold_i,
    input  logic       cs_release_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rx_byte_o,
    output logic       spi_sck_o,
    output logic       spi_copi_o,
    input  logic       spi_cipo_i,
    output logic       spi_cs_n_o
);

    localparam logic [TIMER_W-1:0] HALF_RELOAD = TIMER_W'(CLK_DIV - 1);
    localparam logic [TIMER_W-1:0] IDLE_RELOAD = TIMER_W'(CS_IDLE - 1);

    spi_ctrl_state_t    state;
    logic [7:0]         tx_shift;
    logic [7:0]         rx_shift;
    logic [2:0]         bit_cnt;
    logic               hold;
    logic [1:0]         cipo_sync;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               half_done;

    spi_half_timer u_half_timer (
        .clk        (clk),
        .reset      (reset_i),
        .load       (timer_load),
        .load_value (timer_value),
        .tc         (half_done)
    );

    // Timer reloads on the same edges where the state machine starts a new phase.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = HALF_RELOAD;
        case (state)
            IDLE, HOLD: begin
                if (start_i) begin
                    timer_load = 1'b1;
                end else if (state == HOLD && cs_release_i) begin
                    timer_load  = 1'b1;
                    timer_value = IDLE_RELOAD;
                end
            end
            SHIFT: begin
                if (half_done) begin
                    timer_load = 1'b1;
                    if (spi_sck_o && bit_cnt == 3'd0) begin
                        timer_value = IDLE_RELOAD;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        cipo_sync <= {cipo_sync[0], spi_cipo_i};
        done_o    <= 1'b0;
        if (reset_i) begin
            state      <= IDLE;
            spi_sck_o  <= SPI_SCK_IDLE;
            spi_cs_n_o <= ~SPI_CS_ENABLED;
            spi_copi_o <= 1'b0;
            ready_o    <= 1'b1;
            busy_o     <= 1'b0;
            rx_byte_o  <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            bit_cnt    <= '0;
            hold       <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (start_i) begin
                        state      <= SHIFT;
                        spi_cs_n_o <= SPI_CS_ENABLED;
                        spi_sck_o  <= SPI_SCK_IDLE;
                        spi_copi_o <= tx_byte_i[7];
                        tx_shift   <= {tx_byte_i[6:0], 1'b0};
                        hold       <= cs_hold_i;
                        bit_cnt    <= 3'd7;
                        ready_o    <= 1'b0;
                        busy_o     <= 1'b1;
                    end else if (state == HOLD && cs_release_i) begin
                        state      <= RELEASE;
                        spi_cs_n_o <= ~SPI_CS_ENABLED;
                        ready_o    <= 1'b0;
                        busy_o     <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (half_done) begin
                        if (!spi_sck_o) begin
                            spi_sck_o <= 1'b1;
                        end else begin
                            // Last high cycle of the bit: sample, fall, and either advance or finish.
                            spi_sck_o <= SPI_SCK_IDLE;
                            rx_shift  <= {rx_shift[6:0], cipo_sync[1]};
                            bit_cnt   <= bit_cnt - 3'd1;
                            if (bit_cnt == 3'd0) begin
                                done_o    <= 1'b1;
                                rx_byte_o <= {rx_shift[6:0], cipo_sync[1]};
                                if (hold) begin
                                    state   <= HOLD;
                                    ready_o <= 1'b1;
                                    busy_o  <= 1'b0;
                                end else begin
                                    state      <= RELEASE;
                                    spi_cs_n_o <= ~SPI_CS_ENABLED;
                                end
                            end else begin
                                spi_copi_o <= tx_shift[7];
                                tx_shift   <= {tx_shift[6:0], 1'b0};
                            end
                        end
                    end
                end
                RELEASE: begin
                    if (half_done) begin
                        state   <= IDLE;
                        ready_o <= 1'b1;
                        busy_o  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: cycle-level behavioural model plus an emulated mode-0 target.
module tb_spi_controller;

    localparam int D  = 4;
    localparam int CI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, hold_in, release_in;
    logic [7:0] tx;
    logic       cipo = 1'b0;
    logic       ready, busy, done, sck, copi, cs_n;
    logic [7:0] rx;

    spi_controller #(.CLK_DIV(D), .CS_IDLE(CI)) dut (
        .clk          (clk),
        .reset_i      (reset),
        .start_i      (start),
        .tx_byte_i    (tx),
        .cs_hold_i    (hold_in),
        .cs_release_i (release_in),
        .ready_o      (ready),
        .busy_o       (busy),
        .done_o       (done),
        .rx_byte_o    (rx),
        .spi_sck_o    (sck),
        .spi_copi_o   (copi),
        .spi_cipo_i   (cipo),
        .spi_cs_n_o   (cs_n)
    );

    logic       f_reset, f_start;
    logic [7:0] f_tx;
    logic       f_ready, f_busy, f_done, f_sck, f_copi, f_cs_n;
    logic [7:0] f_rx;

    spi_controller #(.CLK_DIV(1), .CS_IDLE(1)) fast (
        .clk          (clk),
        .reset_i      (f_reset),
        .start_i      (f_start),
        .tx_byte_i    (f_tx),
        .cs_hold_i    (1'b0),
        .cs_release_i (1'b0),
        .ready_o      (f_ready),
        .busy_o       (f_busy),
        .done_o       (f_done),
        .rx_byte_o    (f_rx),
        .spi_sck_o    (f_sck),
        .spi_copi_o   (f_copi),
        .spi_cipo_i   (1'b1),
        .spi_cs_n_o   (f_cs_n)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Emulated target: presents bit 7 while CS is high, moves to the next bit on each SCK fall.
    logic [7:0] tgt = 8'h00;
    initial begin : target_emu
        logic [2:0] idx;
        logic       p_sck;
        idx   = 3'd7;
        p_sck = 1'b0;
        forever begin
            @(negedge clk);
            if (cs_n !== 1'b0) idx = 3'd7;
            else if (p_sck === 1'b1 && sck === 1'b0) idx = idx - 3'd1;
            p_sck = sck;
            cipo  = tgt[idx];
        end
    end

    // Observations written only by the model process.
    int         cyc = 0, accept_cyc = 0, done_cyc = 0, cs_rise_cyc = 0, ready_rise_cyc = 0;
    int         done_total = 0, cs_rise_total = 0, sck_rises = 0;
    logic [7:0] copi_cap = 8'h00;

    initial begin : model
        int         k, rel, ph;
        logic       in_hold, done_now, run, m_hold;
        logic [7:0] m_tx, m_rx, m_tgt;
        logic       e_sck, e_cs, e_ready, e_busy;
        logic       p_sck, p_cs, p_ready;
        k = 0; rel = 0; ph = 0;
        in_hold = 1'b0; done_now = 1'b0; run = 1'b0; m_hold = 1'b0;
        m_tx = 8'h00; m_rx = 8'h00; m_tgt = 8'h00;
        p_sck = 1'b0; p_cs = 1'b0; p_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (run) begin
                e_sck = 1'b0; e_cs = 1'b1; e_ready = 1'b1; e_busy = 1'b0;
                if (k >= 1) begin
                    ph      = (k - 1) / D;
                    e_sck   = ph[0];
                    e_cs    = 1'b0;
                    e_ready = 1'b0;
                    e_busy  = 1'b1;
                    check("copi_shift", copi, m_tx[7 - ph / 2]);
                end else if (rel > 0) begin
                    e_ready = 1'b0;
                    e_busy  = 1'b1;
                end else if (in_hold) begin
                    e_cs = 1'b0;
                    check("copi_hold", copi, m_tx[0]);
                end
                check("cycle", {sck, cs_n, ready, busy, done, rx},
                      {e_sck, e_cs, e_ready, e_busy, done_now, m_rx});
            end
            if (p_sck === 1'b0 && sck === 1'b1) begin
                copi_cap = {copi_cap[6:0], copi};
                sck_rises++;
            end
            if (p_cs === 1'b0 && cs_n === 1'b1) begin
                cs_rise_cyc = cyc;
                cs_rise_total++;
            end
            if (p_ready === 1'b0 && ready === 1'b1) ready_rise_cyc = cyc;
            if (done === 1'b1) begin
                done_cyc = cyc;
                done_total++;
            end
            p_sck = sck; p_cs = cs_n; p_ready = ready;

            done_now = 1'b0;
            if (reset === 1'b1) begin
                k = 0; rel = 0; in_hold = 1'b0; m_rx = 8'h00; run = 1'b1;
            end else if (k >= 1 && k < 16 * D) begin
                k++;
            end else if (k == 16 * D) begin
                k = 0;
                done_now = 1'b1;
                m_rx = m_tgt;
                if (m_hold) in_hold = 1'b1;
                else rel = CI;
            end else if (rel > 0) begin
                rel--;
            end else if (start === 1'b1) begin
                k = 1; m_tx = tx; m_hold = hold_in; m_tgt = tgt; in_hold = 1'b0;
                accept_cyc = cyc;
                sck_rises  = 0;
            end else if (in_hold && release_in === 1'b1) begin
                in_hold = 1'b0;
                rel = CI;
            end
        end
    end

    int   fcyc = 0, f_acc_cyc = 0, f_done_cyc = 0, f_prev_done_cyc = 0, f_done_total = 0, f_tog = 0;
    initial begin : fast_monitor
        logic p;
        p = 1'b0;
        forever begin
            @(negedge clk);
            fcyc++;
            if (f_start === 1'b1 && f_ready === 1'b1) f_acc_cyc = fcyc;
            if (f_done === 1'b1) begin
                f_prev_done_cyc = f_done_cyc;
                f_done_cyc = fcyc;
                f_done_total++;
            end
            if (f_sck !== p) f_tog++;
            p = f_sck;
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) check("ready_timeout", ready, 1);
    endtask

    task automatic send(input logic [7:0] b, input logic [7:0] t, input logic h, input logic r);
        wait_ready();
        tx = b; tgt = t; hold_in = h; release_in = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; release_in = 1'b0;
    endtask

    initial begin : stimulus
        int d0, c0, tog0;
        reset = 1'b1; f_reset = 1'b1; start = 1'b0; hold_in = 1'b0; release_in = 1'b0;
        tx = 8'h00; f_start = 1'b0; f_tx = 8'h00;
        repeat (3) @(posedge clk);
        #1; reset = 1'b0; f_reset = 1'b0;

        check("rst_state", {ready, busy, cs_n, sck, copi, done}, 6'b101000);
        check("rst_rx", rx, 8'h00);
        check("rst_fast", {f_ready, f_cs_n, f_sck}, 3'b110);
        repeat (2) @(posedge clk);
        #1;

        send(8'hA5, 8'h3C, 1'b0, 1'b0);
        repeat (75) @(posedge clk);
        #1;
        check("a5_done_lat", done_cyc - accept_cyc, 65);
        check("a5_rx", rx, 8'h3C);
        check("a5_copi_bits", copi_cap, 8'hA5);
        check("a5_cs_rise", cs_rise_cyc - accept_cyc, 65);
        check("a5_ready_back", ready_rise_cyc - accept_cyc, 69);
        check("a5_sck_pulses", sck_rises, 8);

        d0 = done_total; c0 = cs_rise_total;
        send(8'h12, 8'h81, 1'b1, 1'b0);
        send(8'h34, 8'h7E, 1'b0, 1'b0);
        repeat (80) @(posedge clk);
        #1;
        check("pair_dones", done_total - d0, 2);
        check("pair_cs_rises", cs_rise_total - c0, 1);
        check("pair_rx", rx, 8'h7E);

        c0 = cs_rise_total;
        send(8'h55, 8'hAA, 1'b1, 1'b0);
        send(8'hFF, 8'h0F, 1'b0, 1'b1);
        repeat (80) @(posedge clk);
        #1;
        check("startwins_cs_rises", cs_rise_total - c0, 1);
        check("startwins_cs_rise_at", cs_rise_cyc - accept_cyc, 65);
        check("startwins_sck", sck_rises, 8);
        check("startwins_copi", copi_cap, 8'hFF);
        check("startwins_rx", rx, 8'h0F);

        d0 = done_total;
        send(8'h96, 8'h69, 1'b0, 1'b0);
        repeat (36) @(posedge clk);
        #1; reset = 1'b1;
        @(posedge clk);
        #1; reset = 1'b0;
        check("midrst_state", {cs_n, sck, ready, done}, 4'b1010);
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_done", done_total - d0, 0);
        send(8'h5A, 8'hC3, 1'b0, 1'b0);
        repeat (75) @(posedge clk);
        #1;
        check("midrst_followup_rx", rx, 8'hC3);
        check("midrst_followup_done", done_total - d0, 1);

        for (int i = 0; i < 40; i++) begin
            send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 80)) begin
                if (ready !== 1'b1) begin
                    start = ($urandom_range(0, 3) == 0);
                    release_in = 1'($urandom_range(0, 1));
                end else begin
                    start = 1'b0;
                    release_in = ($urandom_range(0, 7) == 0);
                end
                @(posedge clk); #1;
            end
            start = 1'b0; release_in = 1'b0;
        end
        wait_ready();
        release_in = 1'b1;
        @(posedge clk); #1;
        release_in = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        tog0 = f_tog;
        f_tx = 8'h00;
        if (f_ready === 1'b1) f_start = 1'b1;
        @(posedge clk); #1;
        f_start = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("fast_done_lat", f_done_cyc - f_acc_cyc, 17);
        check("fast_sck_toggles", f_tog - tog0, 16);
        check("fast_rx", f_rx, 8'hFF);

        d0 = f_done_total;
        f_start = 1'b1;
        repeat (54) @(posedge clk);
        #1; f_start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("fast_held_start_dones", f_done_total - d0, 3);
        check("fast_held_start_period", f_done_cyc - f_prev_done_cyc, 18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
